fifo_uart_drain: RTL and testbench
==================================

// Module: fifo_uart_drain
// PURPOSE
//  Read side of the JPEG byte buffer. Pops bytes from the 8-bit FIFO and
//  serializes each one as UART 8N1/8N2, LSB first, on tx. Sits between the
//  FIFO output and the host-bound UART pin on the Nexys4.
//  One clock domain; pops one byte per frame and never overlaps frames.
// PARAMETERS
//  DATO_WIDTH    8    data width of the FIFO byte; the frame always carries exactly 8 data bits
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200 baud); must be >= 2
//  STOP_BITS     1    number of stop bits, 1 or 2
//  CNT_WIDTH     16   width of the sent-byte counter
// PORTS
//  clk       in   1           system clock
//  rst_n     in   1           asynchronous reset, active-low
//  en        in   1           drain enable; sampled only in IDLE
//  empy      in   1           FIFO empty flag
//  datout    in   DATO_WIDTH  FIFO read data; valid 1 cycle after rd_en
//  rd_en     out  1           one-cycle FIFO pop strobe (registered)
//  tx        out  1           UART serial line, idle high
//  busy      out  1           high from POP through the last stop bit
//  sent_cnt  out  CNT_WIDTH   bytes fully transmitted; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx=1, rd_en=0, busy=0, sent_cnt=0,
//   shift reg=0, bit/baud counters=0. Applies immediately, mid-frame too;
//   the partial frame is abandoned and the popped byte is lost.
//  FSM: IDLE -> POP -> LOAD -> START -> DATA -> STOP -> IDLE.
//   IDLE : tx=1. If en && !empy -> POP, else stay.
//   POP  : rd_en=1 for exactly this cycle; busy=1 -> LOAD.
//   LOAD : capture datout into shift reg -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA : tx=shift[0]; every CLKS_PER_BIT cycles shift right; after 8
//          bits -> STOP.
//   STOP : tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on the last cycle
//          sent_cnt+=1 -> IDLE.
//  Latency: IDLE sample at cycle N -> rd_en at N+1 -> capture at N+2 ->
//   tx falls at N+3. Frame = (9+STOP_BITS)*CLKS_PER_BIT cycles of tx.
//  Inter-frame gap: at least one IDLE cycle with tx=1 (min 3 clk idle-high
//   between the stop bit end and the next start bit).
//  en deassert mid-frame: the current frame completes; no new pop follows.
//  empy changes outside IDLE: ignored. rd_en is never asserted while empy=1
//   was sampled in IDLE.
//  Baud counter: counts 0..CLKS_PER_BIT-1; bit boundary when it hits
//   CLKS_PER_BIT-1; cleared on every state entry.
//  Bit counter: 3 bits, 0..7, in DATA only.
//  sent_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
//  tx is driven from a register (glitch-free).
// STRUCTURE
//  Package fifo_uart_pkg: state encoding (IDLE, POP, LOAD, START, DATA,
//   STOP as 3-bit localparams), UART_DATA_BITS=8, default CLKS_PER_BIT.
//  Sub-module uart_baud_tick: counter with clear input, tick out on
//   CLKS_PER_BIT-1.
//  Top holds the FSM, shift register, bit counter and sent_cnt.
// TESTING  (bench uses CLKS_PER_BIT=4, STOP_BITS=1, FIFO model with
//   1-cycle read latency)
//  1 rst_n=0 while tx mid-DATA -> tx=1, rd_en=0, busy=0, sent_cnt=0 in
//    the same cycle; no pop after release while en=0.
//  2 FIFO holds 0xA5, en=1 -> single rd_en pulse; tx: 0 then 1,0,1,0,0,1,0,1,
//    then 1, each bit 4 clk; falls 3 clk after empy sampled low; sent_cnt=1.
//  3 FIFO holds 0x00,0xFF,0x3C -> three frames in order, exactly 3 rd_en
//    pulses, each frame 40 clk, >=3 idle-high clk between, sent_cnt=3.
//  4 en dropped during bit 2 of 0x55 with 2 bytes queued -> frame
//    completes, no further rd_en, empy stays 0, sent_cnt=1.
//  5 empy=1, en=1 for 100 clk -> rd_en never high, tx=1, busy=0.
//  6 STOP_BITS=2, CNT_WIDTH=2, 5 bytes -> stop bit high for 8 clk;
//    sent_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
//  Shared definitions for the FIFO-to-UART drain: the 3-bit state encoding,
//  the fixed number of data bits per frame and the default bit period.
//  No ports; imported by fifo_uart_drain and uart_baud_tick.
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_POP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  // A frame always carries one byte, whatever the FIFO word width is.
  localparam int UART_DATA_BITS = 8;

  // 100 MHz system clock divided down to 115200 baud.
  localparam int DEF_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_POP   = ST_POP,
    S_LOAD  = ST_LOAD,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//  Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick while the
//  count sits on the last value of the period, then wraps to 0.
//  Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active-low
//   clr    in   restart the period from 0 on the next edge
//   tick   out  high during the final cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = fifo_uart_pkg::DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Period counter: cleared on request, wraps at the end of each bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// ---------------------------------------------------------------------------
// fifo_uart_drain
//  Pops bytes from an 8-bit FIFO (1-cycle read latency) and sends each as a
//  UART 8N1/8N2 frame, LSB first. One frame at a time, never overlapped.
//  Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active-low
//   en        in   drain enable, only looked at while idle
//   empy      in   FIFO empty flag, only looked at while idle
//   datout    in   FIFO read data, valid the cycle after rd_en
//   rd_en     out  one-cycle pop strobe (registered)
//   tx        out  serial line, idle high (registered)
//   busy      out  high from the pop cycle through the last stop bit
//   sent_cnt  out  number of complete frames sent, wraps silently
// ---------------------------------------------------------------------------
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int DATO_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empy,
  input  logic [DATO_WIDTH-1:0] datout,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  sent_cnt
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                      state_r, state_s;
  logic [UART_DATA_BITS-1:0]   shift_r, shift_s;
  logic [2:0]                  bit_cnt_r, bit_cnt_s;
  logic                        stop_cnt_r, stop_cnt_s;
  logic                        tx_r, tx_s;
  logic                        rd_en_r, rd_en_s;
  logic                        busy_r, busy_s;
  logic [CNT_WIDTH-1:0]        sent_cnt_r, sent_cnt_s;
  logic                        tick_s;
  logic                        baud_clr_s;
  logic                        stop_last_s;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (baud_clr_s),
    .tick (tick_s)
  );

  assign stop_last_s = (stop_cnt_r == LAST_STOP);

  // Next-state, datapath and next output values
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    sent_cnt_s = sent_cnt_r;

    case (state_r)
      S_IDLE: begin
        if (en && !empy) begin
          state_s = S_POP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_POP: begin
        state_s = S_LOAD;
      end
      S_LOAD: begin
        // datout is valid now, one cycle after the pop strobe
        shift_s = datout[UART_DATA_BITS-1:0];
        state_s = S_START;
      end
      S_START: begin
        if (tick_s) begin
          bit_cnt_s = 3'd0;
          state_s   = S_DATA;
        end else begin
          state_s = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s  = 3'd0;
            stop_cnt_s = 1'b0;
            state_s    = S_STOP;
          end else begin
            shift_s   = {1'b0, shift_r[UART_DATA_BITS-1:1]};
            bit_cnt_s = bit_cnt_r + 3'd1;
            state_s   = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          if (stop_last_s) begin
            sent_cnt_s = sent_cnt_r + CNT_WIDTH'(1'b1);
            state_s    = S_IDLE;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
            state_s    = S_STOP;
          end
        end else begin
          state_s = S_STOP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Every state change restarts the bit period
    baud_clr_s = (state_s != state_r);
    rd_en_s    = (state_s == S_POP);
    busy_s     = (state_s != S_IDLE);

    // Outputs are derived from the next state so the registers line up
    // with the state they belong to
    case (state_s)
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= {UART_DATA_BITS{1'b0}};
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      sent_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      tx_r       <= tx_s;
      rd_en_r    <= rd_en_s;
      busy_r     <= busy_s;
      sent_cnt_r <= sent_cnt_s;
    end
  end

  assign rd_en    = rd_en_r;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign sent_cnt = sent_cnt_r;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_drain
//  Two instances: dut_a (4 clk/bit, 1 stop bit, 16-bit count) and dut_b
//  (4 clk/bit, 2 stop bits, 2-bit count), each fed by a FIFO model with a
//  1-cycle read latency. Frames are decoded from tx at the falling clock
//  edge and checked against a table and a byte scoreboard.
// ---------------------------------------------------------------------------
module tb_fifo_uart_drain;

  localparam int CPB     = 4;
  localparam int TIMEOUT = 200;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] bits;   // line bits in send order, bit 0 = start bit
    logic [15:0] cnt;    // sent_cnt expected after this frame
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        en_a = 1'b0, en_b = 1'b0;
  logic        empy_a, empy_b;
  logic [7:0]  datout_a = 8'h00, datout_b = 8'h00;
  logic        rd_en_a, rd_en_b, tx_a, tx_b, busy_a, busy_b;
  logic [15:0] sent_a;
  logic [1:0]  sent_b;

  // FIFO models: pointers split so each is written by one process only
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [5:0] wr_a = 6'd0, rd_a = 6'd0, wr_b = 6'd0, rd_b = 6'd0;
  int         rd_cnt_a = 0, rd_cnt_b = 0, under_a = 0, under_b = 0;

  logic [7:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;
  vec_t       vec [8];

  assign empy_a = (wr_a == rd_a);
  assign empy_b = (wr_b == rd_b);

  always #5 clk = ~clk;

  fifo_uart_drain #(.DATO_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .empy(empy_a), .datout(datout_a),
    .rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .sent_cnt(sent_a));

  fifo_uart_drain #(.DATO_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .empy(empy_b), .datout(datout_b),
    .rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .sent_cnt(sent_b));

  // FIFO A read port
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      if (wr_a != rd_a) begin
        datout_a <= mem_a[rd_a];
        rd_a     <= rd_a + 6'd1;
      end else begin
        under_a <= under_a + 1;
      end
    end
  end

  // FIFO B read port
  always @(posedge clk) begin
    if (rd_en_b) begin
      rd_cnt_b <= rd_cnt_b + 1;
      if (wr_b != rd_b) begin
        datout_b <= mem_b[rd_b];
        rd_b     <= rd_b + 6'd1;
      end else begin
        under_b <= under_b + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] b, input bit to_sb);
    if (sel == 0) begin
      mem_a[wr_a] = b;
      wr_a = wr_a + 6'd1;
    end else begin
      mem_b[wr_b] = b;
      wr_b = wr_b + 6'd1;
    end
    if (to_sb) exp_q.push_back(b);
  endtask

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en_a = v;
    else en_b = v;
  endtask

  function automatic logic cur_tx(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [15:0] cur_cnt(input int sel);
    return (sel == 0) ? sent_a : {14'd0, sent_b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a start bit, samples every clock of the frame, then checks
  // bit widths, busy, framing, data against the scoreboard, the idle cycle
  // after the frame and sent_cnt. idle = high samples before the start bit.
  task automatic recv_frame(input int sel, input int nstop, input int drop_at,
                            input logic [10:0] exp_bits, input bit use_bits,
                            input logic [15:0] exp_cnt, output int idle);
    logic [10:0] seen;
    logic [10:0] mask;
    logic [7:0]  exp_b;
    bit          got, shape_ok, busy_ok;
    int          nbits;
    seen = 11'h000; got = 1'b0; shape_ok = 1'b1; busy_ok = 1'b1; idle = 0;
    nbits = 9 + nstop;
    mask  = (nstop == 2) ? 11'h7FF : 11'h3FF;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (cur_tx(sel) == 1'b0) begin
        got = 1'b1;
        break;
      end
      idle++;
    end
    check("start_seen", got, 1);
    if (!got) return;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) seen[b] = cur_tx(sel);
        else if (cur_tx(sel) != seen[b]) shape_ok = 1'b0;
        if (!cur_busy(sel)) busy_ok = 1'b0;
        if (b == drop_at && c == 0) set_en(sel, 1'b0);
      end
    end
    @(negedge clk);
    check("bit_width", shape_ok, 1);
    check("busy_frame", busy_ok, 1);
    check("framing", {seen[0], seen[9], (nstop == 2) ? seen[10] : 1'b1}, 3'b011);
    check("sb_pending", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      check("sb_byte", seen[8:1], exp_b);
    end
    if (use_bits) check("frame_bits", seen & mask, exp_bits & mask);
    check("post_idle", {cur_tx(sel), cur_busy(sel)}, 2'b10);
    check("sent_cnt", cur_cnt(sel), exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  idle, base;
    bit  got, tx_ok, rd_ok, busy_ok;

    vec[0] = '{0, 8'h00, 11'b11_00000000_0, 16'd1};
    vec[1] = '{0, 8'hFF, 11'b11_11111111_0, 16'd2};
    vec[2] = '{0, 8'h3C, 11'b11_00111100_0, 16'd3};
    vec[3] = '{1, 8'h01, 11'b11_00000001_0, 16'd1};
    vec[4] = '{1, 8'h80, 11'b11_10000000_0, 16'd2};
    vec[5] = '{1, 8'h5A, 11'b11_01011010_0, 16'd3};
    vec[6] = '{1, 8'hC3, 11'b11_11000011_0, 16'd0};
    vec[7] = '{1, 8'h7E, 11'b11_01111110_0, 16'd1};

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_a", {tx_a, rd_en_a, busy_a, (sent_a == 16'd0)}, 4'b1001);
    check("rst_b", {tx_b, rd_en_b, busy_b, (sent_b == 2'd0)}, 4'b1001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: latency, pattern, one pop
    base = rd_cnt_a;
    push(0, 8'hA5, 1'b1);
    en_a = 1'b1;
    recv_frame(0, 1, -1, 11'b11_10100101_0, 1'b1, 16'd1, idle);
    check("tx_fall_latency", idle, 2);
    check("a5_pops", rd_cnt_a - base, 1);

    // Reset while mid-DATA
    push(0, 8'h0F, 1'b0);
    got = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (tx_a == 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    check("t1_start", got, 1);
    repeat (CPB * 2) @(negedge clk);
    check("t1_mid_busy", busy_a, 1);
    rst_n = 1'b0;
    en_a  = 1'b0;
    #1;
    check("t1_rst_tx", tx_a, 1);
    check("t1_rst_rd", rd_en_a, 0);
    check("t1_rst_busy", busy_a, 0);
    check("t1_rst_cnt", sent_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = rd_cnt_a;
    tx_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_a != 1'b1) tx_ok = 1'b0;
    end
    check("t1_no_pop", rd_cnt_a - base, 0);
    check("t1_tx_idle", tx_ok, 1);

    // Three back-to-back frames from the table
    base = rd_cnt_a;
    for (int i = 0; i < 3; i++) push(vec[i].sel, vec[i].data, 1'b1);
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      recv_frame(vec[i].sel, 1, -1, vec[i].bits, 1'b1, vec[i].cnt, idle);
      check("interframe_gap", (idle >= 2), 1);
    end
    check("t3_pops", rd_cnt_a - base, 3);
    en_a = 1'b0;
    do_reset();

    // en dropped during data bit 2 of 0x55 with two bytes behind it
    base = rd_cnt_a;
    push(0, 8'h55, 1'b1);
    push(0, 8'h12, 1'b1);
    push(0, 8'h34, 1'b1);
    en_a = 1'b1;
    recv_frame(0, 1, 3, 11'b11_01010101_0, 1'b1, 16'd1, idle);
    busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_a) busy_ok = 1'b0;
    end
    check("t4_one_pop", rd_cnt_a - base, 1);
    check("t4_empy", empy_a, 0);
    check("t4_idle", busy_ok, 1);
    en_a = 1'b1;
    recv_frame(0, 1, -1, 11'h000, 1'b0, 16'd2, idle);
    recv_frame(0, 1, -1, 11'h000, 1'b0, 16'd3, idle);
    en_a = 1'b0;

    // Empty FIFO with en held high
    en_a    = 1'b1;
    base    = rd_cnt_a;
    tx_ok   = 1'b1;
    rd_ok   = 1'b1;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rd_en_a) rd_ok = 1'b0;
      if (!tx_a) tx_ok = 1'b0;
      if (busy_a) busy_ok = 1'b0;
    end
    check("t5_rd_en", rd_ok, 1);
    check("t5_tx", tx_ok, 1);
    check("t5_busy", busy_ok, 1);
    check("t5_pops", rd_cnt_a - base, 0);
    en_a = 1'b0;

    // Two stop bits, 2-bit counter wrapping
    base = rd_cnt_b;
    for (int i = 3; i < 8; i++) push(vec[i].sel, vec[i].data, 1'b1);
    en_b = 1'b1;
    for (int i = 3; i < 8; i++) begin
      recv_frame(vec[i].sel, 2, -1, vec[i].bits, 1'b1, vec[i].cnt, idle);
      check("interframe_gap_b", (idle >= 2), 1);
    end
    check("t6_pops", rd_cnt_b - base, 5);
    en_b = 1'b0;

    check("underflow_a", under_a, 0);
    check("underflow_b", under_b, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
